// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial ripple subtractor.
//   - state_e            : FSM states (IDLE, RUN, DONE)
//   - DEFAULT_DATA_WIDTH : default operand/result width
//   - clog2()            : index-counter width helper, never returns less than 1
package serial_ripple_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_DATA_WIDTH = 4;

    // Width needed to count 0..value-1; a 1-wide operand still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// Combinational one-bit full-subtractor cell.
//   a, b : operand bits (a - b)
//   bi   : borrow in
//   d    : difference bit
//   bo   : borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple subtractor: d = (a - b - bin) mod 2^DATA_WIDTH, one bit per clock,
// through a single full_subtractor cell and a registered borrow.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, bin           : minuend, subtrahend, borrow in
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   d, bout             : difference and borrow out, held stable in DONE
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] d,
    output logic                  bout
);

    localparam int IDX_W = clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0] b_sh_q, b_sh_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  br_q, br_d;
    logic                  bout_q, bout_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic cell_d;
    logic cell_bo;

    full_subtractor u_cell (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .bi (br_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = cell_bo;
                // Difference bits enter at the MSB so bit 0 lands in d[0] after the last shift.
                d_d                 = d_q >> 1;
                d_d[DATA_WIDTH-1]   = cell_d;
                if (idx_q == LAST_IDX) begin
                    bout_d  = cell_bo;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake flags come from the state register only.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign d         = d_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          bin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] d;
    logic          bout;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    bit rand_or = 1'b0;

    logic [DW:0] exp_q[$];   // {bout, d}

    serial_ripple_subtractor #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        if (rand_or) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Reference: plain integer subtraction.
    function automatic logic [DW:0] model(input int ia, input int ib, input int ibin);
        int diff;
        diff = ia - ib - ibin;
        return {(diff < 0) ? 1'b1 : 1'b0, DW'(diff & ((1 << DW) - 1))};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: a result is consumed at the edge following a negedge that sees valid & ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("result_d", int'(d), int'(e[DW-1:0]));
                check("result_bout", int'(bout), int'(e[DW]));
            end
        end
    end

    task automatic wait_in_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check({name, "_timeout"}, 0, 1);
    endtask

    // Presents operands, returns after the accepting edge (+1).
    task automatic send(input int ia, input int ib, input int ibin, input bit keep_valid);
        wait_in_ready("send");
        a = DW'(ia); b = DW'(ib); bin = 1'(ibin);
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(ia, ib, ibin));
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int t0;
        int ra, rb, rbin;
        // Reset state
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_d", int'(d), 0);
        check("rst_bout", int'(bout), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        // Latency: 5-3-0
        out_ready = 1'b1;
        send(5, 3, 0, 1'b0);           // edge E0 passed
        repeat (DW - 1) @(posedge clk);
        #1 check("lat_before_E4", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_after_E4", int'(out_valid), 1);
        check("lat_in_ready_low", int'(in_ready), 0);
        @(posedge clk); #1;
        check("lat_in_ready_back", int'(in_ready), 1);
        check("lat_out_valid_low", int'(out_valid), 0);

        // Directed corner vectors
        send(3, 5, 0, 1'b0);  wait_in_ready("v1");
        send(0, 0, 1, 1'b0);  wait_in_ready("v2");
        send(15, 15, 0, 1'b0); wait_in_ready("v3");
        send(0, 15, 1, 1'b0); wait_in_ready("v4");
        send(15, 0, 0, 1'b0); wait_in_ready("v5");

        // Backpressure 9-4
        out_ready = 1'b0;
        send(9, 4, 0, 1'b0);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 4'd1; b = 4'd2; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_d", int'(d), 5);
            check("bp_bout", int'(bout), 0);
            check("bp_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);

        // Reset mid-RUN
        send(12, 1, 0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("midrun_out_valid", int'(out_valid), 0);
        check("midrun_d", int'(d), 0);
        check("midrun_bout", int'(bout), 0);
        check("midrun_in_ready", int'(in_ready), 1);
        @(posedge clk); #3 rst_n = 1'b1;
        send(7, 2, 0, 1'b0);
        wait_in_ready("after_rst");

        // Back-to-back with in_valid held high
        @(posedge clk); #1;
        begin
            int pa[3] = '{1, 2, 8};
            int pb[3] = '{1, 3, 7};
            int prev;
            prev = -1;
            for (int i = 0; i < 3; i++) begin
                send(pa[i], pb[i], 0, 1'b1);
                t0 = cycle;
                if (prev >= 0) check("b2b_interval", t0 - prev, DW + 2);
                prev = t0;
            end
            in_valid = 1'b0;
        end
        drain();

        // Random sweep with random backpressure
        rand_or = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rbin = int'($urandom_range(0, 1));
            send(ra, rb, rbin, 1'b0);
        end
        drain();
        rand_or = 1'b0;
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_ripple_subtractor.md
# serial_ripple_subtractor

Bit-serial ripple subtractor: computes `a - b - bin` one bit per clock through a single full-subtractor cell and a registered borrow. It is the inverse arithmetic counterpart to the combinational ripple adder in the arithmetic examples. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake. It trades `DATA_WIDTH` cycles of latency for one cell of logic.

## Interface
- `DATA_WIDTH`, default 4: operand and result width; must be ≥ 1.
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operands `a`, `b`, `bin` are valid.
- `in_ready` out 1: block accepts operands (high only in IDLE).
- `a` in DATA_WIDTH: minuend, unsigned.
- `b` in DATA_WIDTH: subtrahend, unsigned.
- `bin` in 1: borrow in.
- `out_valid` out 1: result valid (high only in DONE).
- `out_ready` in 1: consumer accepts the result.
- `d` out DATA_WIDTH: difference, `(a - b - bin) mod 2^DATA_WIDTH`.
- `bout` out 1: borrow out; 1 when `a < b + bin`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready = 1`.
  - When `in_valid & in_ready` at an edge, latch `a`, `b` into shift registers, set borrow ← `bin`, set bit index ← 0, and go to RUN.
- RUN: each edge processes bit `i` with `ai = a_sh[0]`, `bi = b_sh[0]`, `br` = borrow.
  - Difference bit: `di = ai ^ bi ^ br`.
  - Next borrow: `br' = (~ai & bi) | (~(ai ^ bi) & br)`.
  - `di` shifts into `d` from the MSB side, so bit 0 ends at `d[0]` after `DATA_WIDTH` shifts.
  - `a_sh` and `b_sh` shift right; the index increments.
  - On the edge processing bit `DATA_WIDTH-1`, go to DONE and set `bout` ← `br'`.
- DONE:
  - `out_valid = 1`; `d` and `bout` are held stable.
  - When `out_valid & out_ready` at an edge, return to IDLE.
- `in_valid` is ignored outside IDLE; `out_ready` is ignored outside DONE.
- Index counter width: `clog2(DATA_WIDTH)`, minimum 1 bit. It counts 0..DATA_WIDTH-1 and must not wrap past that range.
- The block stores no second operand set; `in_ready` stays low until the result is consumed.

## Timing
- Reset values:
  - state = IDLE, so `in_ready = 1` while reset is asserted and after release.
  - `out_valid = 0`, `d = 0`, `bout = 0`.
  - Internal shift registers, borrow and index = 0.
- Latency: operands accepted on edge E0, bit k processed on edge E(k+1), DONE entered on edge E(DATA_WIDTH). `out_valid` is therefore high in the cycle after E(DATA_WIDTH).
- Minimum initiation interval: DATA_WIDTH + 2 cycles (RUN, one DONE cycle with `out_ready = 1`, one IDLE accept cycle).
- `out_ready` held high in DONE: the result is consumed on the first DONE edge.
- Backpressure: `out_ready` low keeps the block in DONE indefinitely, with outputs unchanged.
- Reset asserted mid-RUN or mid-DONE: the block immediately takes the reset values and the partial result is discarded.
- `DATA_WIDTH = 1`: RUN lasts exactly one cycle.
- `in_ready` and `out_valid` are decoded from state only, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package:
  - FSM state enum (IDLE, RUN, DONE).
  - Default `DATA_WIDTH` constant.
  - `clog2` helper for the index width.
- Sub-module `full_subtractor`: combinational cell with inputs `a`, `b`, `bi` and outputs `d`, `bo`, matching the full-adder cell style. It is instantiated once.
- The top level holds the FSM, the operand and result shift registers, the borrow flop and the index counter.

## Test plan
- `a=5, b=3, bin=0`, `out_ready=1` → `out_valid` rises in the cycle after E4; `d=2`, `bout=0`; `in_ready` back high one cycle later.
- `a=3, b=5, bin=0` → `d=14`, `bout=1`. `a=0, b=0, bin=1` → `d=15`, `bout=1`. `a=15, b=15, bin=0` → `d=0`, `bout=0`.
- Backpressure: `a=9, b=4`, hold `out_ready=0` for 10 cycles → `out_valid` stays 1, `d=5`, `bout=0` stable, `in_ready=0`, and an extra `in_valid` pulse is ignored. Then set `out_ready=1` → IDLE on the next edge.
- Reset mid-RUN: drive `rst_n` low two cycles after accept → `out_valid=0`, `d=0`, `bout=0` immediately, `in_ready=1`. A fresh `a=7, b=2` then yields `d=5`.
- Back-to-back: `in_valid` held high with `out_ready=1`, operand pairs (1,1), (2,3), (8,7) → results (0,0), (15,1), (1,0) in order, each accepted every 6 cycles. Random-operand sweep checked against `(a - b - bin) mod 16` and borrow.
